mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Unified instruction/data memory for the multicycle RISC-V core. It is the responder end of the controller's memory interface.
- The initiator drives address, write enable and write data with a valid strobe. The responder accepts one request at a time, inserts a configurable wait-state latency, performs the access, and returns a single-cycle response.
- Sits between the datapath's address mux (PC or ALU result) and the IR and data registers.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 4096, number of words in the array (16 KiB).
- LATENCY, 2, wait cycles between accept and access. Legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store word, 0 = load word.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  DATA_W  load data; 0 for stores and errors.
- resp_err  output  1  qualified by resp_valid; access was rejected.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). No other clock or reset exists.
- Reset values: state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, internal counter = 0.
  - req_ready = (state == IDLE) && !rst, so it is 0 while rst is high.
  - The array contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req_valid && req_ready, latch we, addr and wdata.
  - Load counter with LATENCY-1 and go to WAIT.
- WAIT:
  - Input changes are ignored because the request is latched.
  - If counter != 0, decrement.
  - If counter == 0, perform the access on this edge:
    - write array[addr[ADDR_W-1:2]] for a store, or
    - register the array word into resp_rdata for a load.
  - Set resp_err and go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - Next edge: resp_valid = 0, resp_rdata and resp_err hold their values, go to IDLE.
  - No response backpressure exists; the initiator must sample resp_valid.
- Timing: accept at edge T, access at edge T+LATENCY, resp_valid high in the cycle after T+LATENCY. The earliest next accept is edge T+LATENCY+2.
- Out of range: word index >= DEPTH_WORDS sets resp_err = 1. A store is dropped; a load returns 0.
- Store response: resp_rdata = 0.
- Reset during WAIT: the request is aborted and no array write occurs. During RESP: resp_valid drops on that edge.
- A request presented during WAIT or RESP is not accepted (req_ready = 0); the initiator holds it.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: req_addr[1:0] != 0 sets resp_err = 1. A store is suppressed; a load returns 0. Latency is unchanged.
- Undefined: req_addr[1:0] is ignored and the access is word-aligned by truncation. resp_err reflects only the range check.

Decomposition:
- Package mem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - DATA_W and ADDR_W defaults;
  - LATENCY_MAX = 15;
  - the counter width constant (4 bits).
- Sub-module mem_word_array: single-port synchronous RAM (we, word index, wdata, registered rdata). The FSM, counter and error logic stay in mem_responder.

Test Plan:
- Reset, then LATENCY = 2: store 0xDEADBEEF at 0x40, then load 0x40. Required: each resp_valid arrives 3 cycles after its accept; the load returns 0xDEADBEEF with resp_err = 0.
- Back-to-back: req_valid held high continuously for two loads. Required: req_ready is low during WAIT and RESP, and the second accept lands exactly at edge T+LATENCY+2.
- Out of range: store to word index 4096 (addr 0x4000), then load 0x4000. Required: both responses have resp_err = 1, the load returns 0, and address 0x0 is unchanged.
- Reset during WAIT of a store of 0x12345678 to 0x80. Required: no response, and a subsequent load of 0x80 returns the prior contents.
- MEM_MISALIGN_TRAP_EN:
  - Defined: store 0xAA to 0x41. Required: resp_err = 1 and address 0x40 is unchanged.
  - Undefined: the same store writes word 0x40 with resp_err = 0.
- LATENCY = 1 and LATENCY = 15 builds: load. Required: resp_valid arrives at accept+2 and accept+16 cycles respectively.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
// Holds the FSM state encoding, default bus widths and wait-counter sizing.
package mem_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter is loaded with LATENCY-1 so that the access lands LATENCY
    // edges after acceptance; out-of-range latencies are clamped to 1..LATENCY_MAX.
    function automatic logic [CNT_W-1:0] wait_count(input int latency);
        int lat;
        lat = latency;
        if (lat < 1) begin
            lat = 1;
        end
        if (lat > LATENCY_MAX) begin
            lat = LATENCY_MAX;
        end
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory controller (master) and
// the memory responder (slave): one outstanding request, one-cycle response.
interface mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/mem_responder_word_array.sv
// Single-port synchronous word RAM with registered read data.
// Contents are never reset; the read register only updates on a read strobe.
module mem_word_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[idx] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[idx];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Unified I/D memory responder: latches one request, waits LATENCY cycles, accesses
// the word array and returns a one-cycle response. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam int               WIDX_W   = ADDR_W - 2;
    localparam logic [CNT_W-1:0] CNT_INIT = wait_count(LATENCY);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              resp_valid_reg;
    logic              resp_err_reg;
    logic              rdata_hit_reg;

    logic              req_ready_int;
    logic              accept;
    logic [WIDX_W-1:0] word_idx;
    logic              in_range;
    logic              access_ok;
    logic              access_now;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    assign req_ready_int = (state_reg == IDLE) && !rst;
    assign accept        = bus.req_valid && req_ready_int;

    assign word_idx = addr_reg[ADDR_W-1:2];
    assign in_range = (word_idx < WIDX_W'(DEPTH_WORDS));

`ifdef MEM_MISALIGN_TRAP_EN
    assign access_ok = in_range && (addr_reg[1:0] == 2'b00);
`else
    // Byte offset is dropped: accesses are word-aligned by truncation.
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr_reg[1:0];
    assign access_ok      = in_range;
`endif

    // A reset on the access edge must abort the request, so the RAM strobes are gated by rst.
    assign access_now = (state_reg == WAIT) && (cnt_reg == '0) && !rst;
    assign ram_we     = access_now && we_reg && access_ok;
    assign ram_re     = access_now && !we_reg && access_ok;

    mem_word_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH_WORDS),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (word_idx[IDX_W-1:0]),
        .wdata (wdata_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            rdata_hit_reg  <= 1'b0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg    <= bus.req_we;
                        addr_reg  <= bus.req_addr;
                        wdata_reg <= bus.req_wdata;
                        cnt_reg   <= CNT_INIT;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        resp_err_reg   <= !access_ok;
                        rdata_hit_reg  <= !we_reg && access_ok;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The RAM read register holds until the next load, so the data only needs
    // qualifying: stores and rejected accesses report zero.
    assign bus.req_ready  = req_ready_int;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.resp_rdata = rdata_hit_reg ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed cases plus random traffic checked against a
// word-indexed reference memory. Honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4096;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_l1 ();
    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_l15 ();

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
        .clk (clk), .rst (rst), .bus (bus_l1)
    );
    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LATENCY(15)) dut_l15 (
        .clk (clk), .rst (rst), .bus (bus_l15)
    );

    // Side instances (latency 1 and 15) are driven through small arrays.
    logic        aux_valid [2];
    logic        aux_we    [2];
    logic [31:0] aux_addr  [2];
    logic [31:0] aux_wdata [2];
    logic        aux_rdy   [2];
    logic        aux_rv    [2];
    logic [31:0] aux_rd    [2];
    logic        aux_err   [2];

    assign bus_l1.req_valid  = aux_valid[0];
    assign bus_l1.req_we     = aux_we[0];
    assign bus_l1.req_addr   = aux_addr[0];
    assign bus_l1.req_wdata  = aux_wdata[0];
    assign bus_l15.req_valid = aux_valid[1];
    assign bus_l15.req_we    = aux_we[1];
    assign bus_l15.req_addr  = aux_addr[1];
    assign bus_l15.req_wdata = aux_wdata[1];
    assign aux_rdy[0] = bus_l1.req_ready;
    assign aux_rv[0]  = bus_l1.resp_valid;
    assign aux_rd[0]  = bus_l1.resp_rdata;
    assign aux_err[0] = bus_l1.resp_err;
    assign aux_rdy[1] = bus_l15.req_ready;
    assign aux_rv[1]  = bus_l15.resp_valid;
    assign aux_rd[1]  = bus_l15.resp_rdata;
    assign aux_err[1] = bus_l15.resp_err;

    // Reference memory keyed by word index.
    logic [31:0] ref_mem [int unsigned];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_access(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       output logic [31:0] exp_rdata, output logic exp_err);
        int unsigned w;
        logic ok;
        w  = addr >> 2;
        ok = (w < DEPTH);
`ifdef MEM_MISALIGN_TRAP_EN
        if (addr[1:0] != 2'b00) ok = 1'b0;
`endif
        exp_err   = !ok;
        exp_rdata = 32'h0;
        if (ok && we) begin
            ref_mem[w] = wdata;
        end else if (ok && ref_mem.exists(w)) begin
            exp_rdata = ref_mem[w];
        end
    endfunction

    // One request on the main instance; cycles = edges from accept to the edge
    // at which the initiator samples resp_valid.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int cycles);
        int n;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ready_idle", bus.req_ready, 1);
        bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_we = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
        cycles = 0;
        do begin
            check("ready_busy", bus.req_ready, 0);
            @(posedge clk); #1; cycles++;
        end while (!bus.resp_valid && cycles < 40);
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        cycles++;
        @(posedge clk); #1;
        check("resp_pulse", bus.resp_valid, 0);
        check("rdata_hold", bus.resp_rdata, rdata);
        check("err_hold", bus.resp_err, err);
    endtask

    task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        int          cyc;
        logic [31:0] exp_rd;
        logic        exp_err;
        xact(we, addr, wdata, rdata, err, cyc);
        ref_access(we, addr, wdata, exp_rd, exp_err);
        $display("xact we=%0d addr=%08h wdata=%08h rdata=%08h err=%0d cycles=%0d",
                 we, addr, wdata, rdata, err, cyc);
        check("latency", cyc, LAT + 1);
        check("err", err, exp_err);
        check("rdata", rdata, exp_rd);
    endtask

    task automatic aux_xact(input int sel, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int cycles,
                            output logic [31:0] rdata, output logic err);
        int n;
        n = 0;
        while (!aux_rdy[sel] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        aux_we[sel] = we; aux_addr[sel] = addr; aux_wdata[sel] = wdata; aux_valid[sel] = 1'b1;
        @(posedge clk); #1;
        aux_valid[sel] = 1'b0;
        cycles = 0;
        do begin
            @(posedge clk); #1; cycles++;
        end while (!aux_rv[sel] && cycles < 40);
        rdata = aux_rd[sel];
        err   = aux_err[sel];
        cycles++;
        $display("aux%0d we=%0d addr=%08h rdata=%08h err=%0d cycles=%0d",
                 sel, we, addr, rdata, err, cycles);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        logic [31:0] a;
        logic        w;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            aux_valid[i] = 1'b0; aux_we[i] = 1'b0; aux_addr[i] = '0; aux_wdata[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.req_ready, 0);
        check("rst_valid", bus.resp_valid, 0);
        check("rst_rdata", bus.resp_rdata, 0);
        check("rst_err", bus.resp_err, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", bus.req_ready, 1);

        // Store then load at 0x40
        run(1'b1, 32'h40, 32'hDEADBEEF, rd, er);
        check("store_rdata_zero", rd, 0);
        run(1'b0, 32'h40, 32'h0, rd, er);
        check("load_40", rd, 32'hDEADBEEF);
        check("load_40_err", er, 0);

        // Out of range
        run(1'b1, 32'h0, 32'h0BADF00D, rd, er);
        run(1'b1, 32'h4000, 32'h11111111, rd, er);
        check("oor_store_err", er, 1);
        run(1'b0, 32'h4000, 32'h0, rd, er);
        check("oor_load_err", er, 1);
        check("oor_load_zero", rd, 0);
        run(1'b0, 32'h0, 32'h0, rd, er);
        check("addr0_intact", rd, 32'h0BADF00D);

        // Back-to-back loads with req_valid held high
        bus.req_we = 1'b0; bus.req_addr = 32'h40; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_addr = 32'h0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk); #1;
            check("b2b_ready", bus.req_ready, (k == LAT + 1));
            check("b2b_valid", bus.resp_valid, (k == LAT));
            if (k == LAT) check("b2b_rdata0", bus.resp_rdata, 32'hDEADBEEF);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("b2b_second_accept", bus.req_ready, 0);
        cyc = 0;
        while (!bus.resp_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        $display("b2b second load rdata=%08h err=%0d", bus.resp_rdata, bus.resp_err);
        check("b2b_rdata1", bus.resp_rdata, 32'h0BADF00D);
        check("b2b_lat1", cyc, LAT);
        @(posedge clk); #1;

        // Reset during WAIT of a store
        run(1'b1, 32'h80, 32'hCAFEF00D, rd, er);
        bus.req_we = 1'b1; bus.req_addr = 32'h80; bus.req_wdata = 32'h12345678; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("wait_rst_ready", bus.req_ready, 0);
        check("wait_rst_valid", bus.resp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("abort_no_resp", bus.resp_valid, 0);
        end
        $display("reset during WAIT of store 0x12345678 to 0x80");
        run(1'b0, 32'h80, 32'h0, rd, er);
        check("abort_kept_old", rd, 32'hCAFEF00D);

        // Misaligned store
        run(1'b1, 32'h41, 32'hAA, rd, er);
`ifdef MEM_MISALIGN_TRAP_EN
        check("misalign_err", er, 1);
        run(1'b0, 32'h40, 32'h0, rd, er);
        check("misalign_word40", rd, 32'hDEADBEEF);
`else
        check("misalign_err", er, 0);
        run(1'b0, 32'h40, 32'h0, rd, er);
        check("misalign_word40", rd, 32'hAA);
`endif

        // Latency 1 and 15 instances
        aux_xact(0, 1'b1, 32'h10, 32'h5A5A1234, cyc, rd, er);
        check("l1_store_lat", cyc, 2);
        aux_xact(0, 1'b0, 32'h10, 32'h0, cyc, rd, er);
        check("l1_load_lat", cyc, 2);
        check("l1_load_data", rd, 32'h5A5A1234);
        check("l1_load_err", er, 0);
        aux_xact(1, 1'b1, 32'h10, 32'hA5A54321, cyc, rd, er);
        check("l15_store_lat", cyc, 16);
        aux_xact(1, 1'b0, 32'h10, 32'h0, cyc, rd, er);
        check("l15_load_lat", cyc, 16);
        check("l15_load_data", rd, 32'hA5A54321);
        check("l15_load_err", er, 0);

        // Random traffic over a small word pool plus out-of-range and misaligned addresses
        for (int i = 0; i < 16; i++) begin
            run(1'b1, 32'h200 + 32'(4 * i), $urandom, rd, er);
        end
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = {30'($urandom_range(DEPTH, 32'h3FFF_FFFF)), 2'b00};
            end else begin
                a = {30'(128 + $urandom_range(0, 15)), 2'b00};
            end
            if ($urandom_range(0, 3) == 0) begin
                a[1:0] = 2'($urandom_range(1, 3));
            end
            w = 1'($urandom_range(0, 1));
            run(w, a, $urandom, rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
